// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle fetch / operand-read / write-back / commit
//               controller for the TP-ISA datapath, with run/step control.
// Revision    : 1.0
// ============================================================================

package types;
  typedef logic [15:0] instr_t;

  localparam logic [3:0] op_store  = 4'h8;
  localparam logic [3:0] op_br     = 4'h9;
  localparam logic [3:0] op_brn    = 4'hA;
  localparam logic [3:0] op_setbar = 4'hB;

  function automatic logic [3:0] opcode_of(input instr_t i);
    return i[15:12];
  endfunction
endpackage

module core_sequencer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  output logic                  busy,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  types::instr_t         imem_rdata,
  output types::instr_t         instr,
  input  logic [ADDR_WIDTH-1:0] dp_addr [1:2],
  input  logic [WIDTH-1:0]      dp_wdata,
  output logic [WIDTH-1:0]      rdata [1:2],
  output logic                  dp_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_RD1    = 3'd2,
    S_RD2    = 3'd3,
    S_WB     = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  types::instr_t   r_instr;
  logic [WIDTH-1:0] r_rdata1;
  logic [WIDTH-1:0] r_rdata2;
  logic            r_step;
  logic [3:0]      w_cur_op;

  // First memory phase of an instruction, decided from the word being fetched.
  function automatic state_t first_phase(input logic [3:0] op);
    if (op == types::op_store)
      return S_WB;
    else if (op == types::op_br || op == types::op_brn)
      return S_COMMIT;
    else if (op == types::op_setbar)
      return S_RD2;
    else
      return S_RD1;
  endfunction

  assign w_cur_op  = types::opcode_of(r_instr);
  assign busy      = (r_state != S_IDLE);
  assign imem_addr = pc;
  assign instr     = r_instr;
  assign rdata[1]  = r_rdata1;
  assign rdata[2]  = r_rdata2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_step   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && !run && step)
        r_step <= 1'b1;
      else if (r_state == S_COMMIT)
        r_step <= 1'b0;
      if (r_state == S_FETCH && imem_ack)
        r_instr <= imem_rdata;
      if (r_state == S_RD1 && mem_ack)
        r_rdata1 <= mem_rdata;
      if (r_state == S_RD2 && mem_ack)
        r_rdata2 <= mem_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dp_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || step)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          w_next = first_phase(types::opcode_of(imem_rdata));
      end
      S_RD1: begin
        mem_req  = 1'b1;
        mem_addr = dp_addr[1];
        if (mem_ack)
          w_next = S_RD2;
      end
      S_RD2: begin
        mem_req  = 1'b1;
        mem_addr = dp_addr[2];
        if (mem_ack)
          w_next = (w_cur_op == types::op_setbar) ? S_COMMIT : S_WB;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dp_addr[1];
        mem_wdata = dp_wdata;
        if (mem_ack)
          w_next = S_COMMIT;
      end
      S_COMMIT: begin
        dp_en  = 1'b1;
        // A pending single step halts here even if run rose meanwhile.
        w_next = (run && !r_step) ? S_FETCH : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
